sht40_convert: RTL and testbench
================================

SHT40_CONVERT -- requirements
Module: sht40_convert

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: Rst_N  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: Temperature_Output  in  16  raw SHT40 temperature word S_T.
REQ-004 SHALL have ports: Humidity_Output  in  16  raw SHT40 humidity word S_RH.
REQ-005 SHALL have ports: Temp_Ready_Out  in  1  level, S_T valid.
REQ-006 SHALL have ports: RH_Ready_Out  in  1  level, S_RH valid.
REQ-007 SHALL have ports: Result_Ready  in  1  consumer accepts result.
REQ-008 SHALL have ports: Temp_Centi  out  16  signed temperature, 0.01 degC units.
REQ-009 SHALL have ports: RH_Centi  out  16  signed humidity, 0.01 %RH units.
REQ-010 SHALL have ports: Result_Valid  out  1  result pair held valid.
REQ-011 SHALL have ports: Busy  out  1  conversion in progress.
REQ-012 SHALL have ports: Overrun  out  1  sticky, a raw pair was dropped.
REQ-013 SHALL use one clock; reset asynchronous, active-low.

Function
REQ-014 SHALL start a conversion when Temp_Ready_Out and RH_Ready_Out are both high, the arm bit is set and the state is IDLE; both raw words are latched on that edge.
REQ-015 SHALL clear the arm bit on start; re-arm when either ready input is low; one conversion per ready pair.
REQ-016 SHALL implement states IDLE -> MUL_T (16 cycles) -> MUL_RH (16 cycles) -> FINISH (1 cycle) -> HOLD -> IDLE.
REQ-017 SHALL multiply serially by shift-add, one multiplier bit per cycle, 31-bit unsigned product.
REQ-018 SHALL compute Temp_Centi = ((17500 * S_T) >> 16) - 4500, truncating; signed 16-bit result.
REQ-019 SHALL compute RH_Centi = ((12500 * S_RH) >> 16) - 600, truncating; signed 16-bit result.
REQ-020 SHALL assert Result_Valid exactly 34 cycles after the start edge; Busy high from cycle 1 through cycle 33.
REQ-021 SHALL hold Result_Valid, Temp_Centi and RH_Centi stable in HOLD until Result_Ready is sampled high; return to IDLE the following cycle.
REQ-022 SHALL, when Result_Valid and Result_Ready are high on the same edge as a new start condition, complete the handshake first; the new pair starts from IDLE on the next edge if still armed.
REQ-023 SHALL set Overrun when a start condition (both ready, armed) occurs outside IDLE; the pair is discarded and the arm bit is cleared.
REQ-024 SHALL keep outputs unchanged outside FINISH except on reset.

Reset
REQ-025 SHALL on Rst_N low immediately force IDLE, arm=1, Temp_Centi=0, RH_Centi=0, Result_Valid=0, Busy=0, Overrun=0.
REQ-026 SHALL abort any in-flight conversion on reset; no partial result is ever presented.
REQ-027 SHALL clear Overrun only on reset.

Configuration
REQ-028 SHALL with SHT40_RH_CLAMP_EN defined clamp RH_Centi to [0, 10000] in FINISH.
REQ-029 SHALL without SHT40_RH_CLAMP_EN present the unclamped range -600..11899.
REQ-030 SHALL never clamp Temp_Centi in either build.

Structure
REQ-031 SHALL place constants 17500, 12500, 4500, 600, 10000, cycle count 16 and the state encoding in package sht40_conv_pkg.
REQ-032 SHALL instantiate one sub-module sht40_serial_mul (start, 16-bit operand, 15-bit constant, done, 31-bit product), reused for T then RH.

Verification
REQ-033 SHALL cover: S_T=0x6666, S_RH=0x8000, both ready -> at cycle 34 Temp_Centi=2499, RH_Centi=5650, Result_Valid=1.
REQ-034 SHALL cover: S_T=0x0000, S_RH=0x0000 -> Temp_Centi=0xEE6C (-4500); RH_Centi=0 with clamp, 0xFDA8 (-600) without.
REQ-035 SHALL cover: S_T=0xFFFF, S_RH=0xFFFF -> Temp_Centi=12999; RH_Centi=10000 with clamp, 11899 without.
REQ-036 SHALL cover: Result_Ready held low 50 cycles -> outputs stable throughout; ready pulse -> Result_Valid low next cycle.
REQ-037 SHALL cover: ready pair dropped low and re-raised at cycle 10 -> Overrun=1, first result unchanged, no second result.
REQ-038 SHALL cover: Rst_N low at cycle 20 of a conversion -> all outputs 0, IDLE immediately; new pair after release converts correctly.

Source files
------------

// File: rtl/sht40_conv_pkg.sv
// Shared constants, state encoding and RH clamp helper for the SHT40 raw-to-centi converter.
package sht40_conv_pkg;

  // Scale factors: T = 175 * S / 65536 - 45, RH = 125 * S / 65536 - 6, both in 0.01 units.
  localparam logic [14:0] TempScale  = 15'd17500;
  localparam logic [14:0] RhScale    = 15'd12500;
  localparam logic [15:0] TempOffset = 16'd4500;
  localparam logic [15:0] RhOffset   = 16'd600;
  localparam logic [15:0] RhMax      = 16'd10000;

  // One multiplier bit per cycle over a 16-bit operand.
  localparam int unsigned MulCycles = 16;
  localparam logic [4:0]  MulCnt    = 5'(MulCycles);

  // Controller state encoding.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StMulT   = 3'd1;
  localparam logic [2:0] StMulRh  = 3'd2;
  localparam logic [2:0] StFinish = 3'd3;
  localparam logic [2:0] StHold   = 3'd4;

  // Limit a signed centi-RH value to the physical range 0..10000.
  function automatic logic [15:0] clamp_rh(input logic [15:0] rh);
    if (rh[15]) begin
      return 16'd0;
    end else if (rh > RhMax) begin
      return RhMax;
    end
    return rh;
  endfunction

endpackage

// File: rtl/sht40_serial_mul.sv
// Serial shift-add multiplier: 16-bit operand times 15-bit constant, 31-bit unsigned product.
// Bit 0 is folded in on the start edge, the remaining 15 bits one per cycle, so done rises
// 16 cycles after start (counting the start cycle) and the product then holds until restarted.
module sht40_serial_mul
  import sht40_conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] operand,
  input  logic [14:0] constant,
  output logic        done,
  output logic [30:0] product
);

  logic [30:0] acc_q;
  logic [30:0] mcand_q;
  logic [14:0] mplier_q;
  logic [4:0]  cnt_q;

  // Load on start, then accumulate one shifted partial product per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= MulCnt;
    end else if (start) begin
      acc_q    <= operand[0] ? {16'd0, constant} : 31'd0;
      mcand_q  <= {15'd0, constant, 1'b0};
      mplier_q <= operand[15:1];
      cnt_q    <= 5'd1;
    end else if (cnt_q != MulCnt) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : 31'd0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 5'd1;
    end
  end

  assign done    = (cnt_q == MulCnt);
  assign product = acc_q;

endmodule

// File: rtl/sht40_convert.sv
// SHT40 raw word to centi-degC / centi-%RH converter with a hold/ready result handshake.
// One shared serial multiplier is used for temperature, then humidity.
// Build option: define SHT40_RH_CLAMP_EN to clamp RH_Centi to 0..10000.
module sht40_convert
  import sht40_conv_pkg::*;
(
  input  logic        clk,
  input  logic        Rst_N,
  input  logic [15:0] Temperature_Output,
  input  logic [15:0] Humidity_Output,
  input  logic        Temp_Ready_Out,
  input  logic        RH_Ready_Out,
  input  logic        Result_Ready,
  output logic [15:0] Temp_Centi,
  output logic [15:0] RH_Centi,
  output logic        Result_Valid,
  output logic        Busy,
  output logic        Overrun
);

  logic [2:0]  state_q, state_d;
  logic        arm_q;
  logic [15:0] raw_rh_q;
  logic [14:0] t_scaled_q;
  logic [15:0] temp_q, rh_q;
  logic        valid_q;
  logic        overrun_q;

  logic        pair_rdy, start_cond, handshake, start_go, drop;
  logic        mul_start, mul_done;
  logic [15:0] mul_op;
  logic [14:0] mul_k;
  logic [30:0] mul_product;
  logic [15:0] temp_calc, rh_calc, rh_final;
  logic        unused_prod;

  // A new pair is only taken from IDLE; a HOLD handshake wins over a coincident start.
  assign pair_rdy   = Temp_Ready_Out & RH_Ready_Out;
  assign start_cond = pair_rdy & arm_q;
  assign handshake  = (state_q == StHold) & Result_Ready;
  assign start_go   = start_cond & (state_q == StIdle);
  assign drop       = start_cond & (state_q != StIdle) & ~handshake;

  // Temperature is fed straight from the input on the start edge; RH from its latched copy.
  assign mul_start = start_go | ((state_q == StMulT) & mul_done);
  assign mul_op    = (state_q == StIdle) ? Temperature_Output : raw_rh_q;
  assign mul_k     = (state_q == StIdle) ? TempScale : RhScale;

  sht40_serial_mul u_mul (
    .clk      (clk),
    .rst_n    (Rst_N),
    .start    (mul_start),
    .operand  (mul_op),
    .constant (mul_k),
    .done     (mul_done),
    .product  (mul_product)
  );

  assign unused_prod = ^mul_product[15:0];

  // Results fit in 16 bits signed, so plain 16-bit wrap-around subtraction is exact.
  assign temp_calc = {1'b0, t_scaled_q} - TempOffset;
  assign rh_calc   = {1'b0, mul_product[30:16]} - RhOffset;

`ifdef SHT40_RH_CLAMP_EN
  assign rh_final = clamp_rh(rh_calc);
`else
  assign rh_final = rh_calc;
`endif

  // Next-state sequencing of the conversion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_go) state_d = StMulT;
      StMulT:   if (mul_done) state_d = StMulRh;
      StMulRh:  if (mul_done) state_d = StFinish;
      StFinish: state_d = StHold;
      StHold:   if (Result_Ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, arm/overrun bookkeeping, operand latch and result registers.
  always_ff @(posedge clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q    <= StIdle;
      arm_q      <= 1'b1;
      raw_rh_q   <= '0;
      t_scaled_q <= '0;
      temp_q     <= '0;
      rh_q       <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!pair_rdy) begin
        arm_q <= 1'b1;
      end else if (start_go || drop) begin
        arm_q <= 1'b0;
      end
      if (drop) overrun_q <= 1'b1;
      if (start_go) raw_rh_q <= Humidity_Output;
      if ((state_q == StMulT) && mul_done) t_scaled_q <= mul_product[30:16];
      if (state_q == StFinish) begin
        temp_q  <= temp_calc;
        rh_q    <= rh_final;
        valid_q <= 1'b1;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign Temp_Centi   = temp_q;
  assign RH_Centi     = rh_q;
  assign Result_Valid = valid_q;
  assign Busy         = (state_q == StMulT) | (state_q == StMulRh) | (state_q == StFinish);
  assign Overrun      = overrun_q;

endmodule

// File: tb/tb_sht40_convert.sv
// Directed bench for sht40_convert. Cycle n of a conversion is the clock period that follows
// the (n-1)th edge after the start edge, so cycle 1 follows the start edge itself.
module tb_sht40_convert;

  logic        clk;
  logic        rst_n;
  logic [15:0] t_raw, rh_raw;
  logic        t_rdy, rh_rdy, res_rdy;
  logic [15:0] temp_c, rh_c;
  logic        valid, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SHT40_RH_CLAMP_EN
  localparam logic [15:0] RhZero = 16'd0;
  localparam logic [15:0] RhFull = 16'd10000;
`else
  localparam logic [15:0] RhZero = 16'hFDA8;
  localparam logic [15:0] RhFull = 16'd11899;
`endif

  sht40_convert dut (
    .clk                (clk),
    .Rst_N              (rst_n),
    .Temperature_Output (t_raw),
    .Humidity_Output    (rh_raw),
    .Temp_Ready_Out     (t_rdy),
    .RH_Ready_Out       (rh_rdy),
    .Result_Ready       (res_rdy),
    .Temp_Centi         (temp_c),
    .RH_Centi           (rh_c),
    .Result_Valid       (valid),
    .Busy               (busy),
    .Overrun            (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic ack();
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; t_raw = '0; rh_raw = '0; t_rdy = 0; rh_rdy = 0; res_rdy = 0;
    #12;
    chk16("rst_temp", temp_c, 16'd0);
    chk16("rst_rh", rh_c, 16'd0);
    chk1("rst_valid", valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    chk1("idle_busy", busy, 1'b0);

    // A: 0x6666 / 0x8000, then a 50-cycle stall on Result_Ready.
    t_raw = 16'h6666; rh_raw = 16'h8000; t_rdy = 1; rh_rdy = 1;
    tick();
    chk1("a_c1_busy", busy, 1'b1);
    chk1("a_c1_valid", valid, 1'b0);
    repeat (32) tick();
    chk1("a_c33_busy", busy, 1'b1);
    chk1("a_c33_valid", valid, 1'b0);
    tick();
    chk1("a_c34_valid", valid, 1'b1);
    chk1("a_c34_busy", busy, 1'b0);
    chk16("a_temp", temp_c, 16'd2499);
    chk16("a_rh", rh_c, 16'd5650);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk1("a_hold_valid", valid, 1'b1);
      chk16("a_hold_temp", temp_c, 16'd2499);
      chk16("a_hold_rh", rh_c, 16'd5650);
    end
    ack();
    chk1("a_ack_valid", valid, 1'b0);
    chk1("a_ack_busy", busy, 1'b0);
    chk1("a_overrun", overrun, 1'b0);

    // B: all-zero raw words.
    t_rdy = 0; rh_rdy = 0;
    tick();
    t_raw = 16'h0000; rh_raw = 16'h0000; t_rdy = 1; rh_rdy = 1;
    repeat (34) tick();
    chk1("b_valid", valid, 1'b1);
    chk16("b_temp", temp_c, 16'hEE6C);
    chk16("b_rh", rh_c, RhZero);
    ack();

    // C: full-scale raw words.
    t_rdy = 0; rh_rdy = 0;
    tick();
    t_raw = 16'hFFFF; rh_raw = 16'hFFFF; t_rdy = 1; rh_rdy = 1;
    repeat (34) tick();
    chk1("c_valid", valid, 1'b1);
    chk16("c_temp", temp_c, 16'd12999);
    chk16("c_rh", rh_c, RhFull);

    // Re-arm in HOLD, then handshake on the same edge as a new start condition.
    t_rdy = 0; rh_rdy = 0;
    tick();
    chk1("c_still_valid", valid, 1'b1);
    t_raw = 16'h4000; rh_raw = 16'h4000; t_rdy = 1; rh_rdy = 1; res_rdy = 1;
    tick();
    res_rdy = 0;
    chk1("hs_valid", valid, 1'b0);
    chk1("hs_busy", busy, 1'b0);
    chk1("hs_overrun", overrun, 1'b0);

    // D: starts from IDLE; pair dropped at cycle 5 and re-raised at cycle 10 -> overrun.
    tick();
    chk1("d_c1_busy", busy, 1'b1);
    repeat (4) tick();
    t_rdy = 0; rh_rdy = 0;
    repeat (5) tick();
    t_raw = 16'hFFFF; rh_raw = 16'hFFFF; t_rdy = 1; rh_rdy = 1;
    tick();
    chk1("d_overrun", overrun, 1'b1);
    chk1("d_c11_busy", busy, 1'b1);
    repeat (23) tick();
    chk1("d_valid", valid, 1'b1);
    chk16("d_temp", temp_c, 16'hFF83);
    chk16("d_rh", rh_c, 16'd2525);
    ack();
    chk1("d_ack_valid", valid, 1'b0);
    repeat (40) tick();
    chk1("d_no_second_valid", valid, 1'b0);
    chk1("d_no_second_busy", busy, 1'b0);
    chk1("d_overrun_sticky", overrun, 1'b1);

    // E: reset at cycle 20, then a fresh full-scale pair after release.
    t_rdy = 0; rh_rdy = 0;
    tick();
    t_raw = 16'h6666; rh_raw = 16'h8000; t_rdy = 1; rh_rdy = 1;
    tick();
    repeat (19) tick();
    chk1("e_c20_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk16("e_rst_temp", temp_c, 16'd0);
    chk16("e_rst_rh", rh_c, 16'd0);
    chk1("e_rst_valid", valid, 1'b0);
    chk1("e_rst_busy", busy, 1'b0);
    chk1("e_rst_overrun", overrun, 1'b0);
    t_raw = 16'hFFFF; rh_raw = 16'hFFFF;
    #1 rst_n = 1'b1;
    tick();
    chk1("e_c1_busy", busy, 1'b1);
    chk1("e_c1_valid", valid, 1'b0);
    repeat (33) tick();
    chk1("e_valid", valid, 1'b1);
    chk16("e_temp", temp_c, 16'd12999);
    chk16("e_rh", rh_c, RhFull);
    ack();
    chk1("e_ack_valid", valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
